// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: one 4-bit magnitude comparator shared among NREQ
// requesters through a round-robin arbiter, one result in flight at a time.

// Plain unsigned 4-bit magnitude comparator.
module magnitude_comparator (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_gt,
  output logic       o_lt,
  output logic       o_eq
);
  assign o_gt = (i_a > i_b);
  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);
endmodule

module cmp_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [4*NREQ-1:0] i_req_a,
  input  logic [4*NREQ-1:0] i_req_b,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_rsp_valid,
  output logic [IDW-1:0]    o_rsp_id,
  output logic              o_rsp_gt,
  output logic              o_rsp_lt,
  output logic              o_rsp_eq,
  input  logic              i_rsp_ready,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

  state_t         r_state, w_next;
  logic [IDW-1:0] r_rr_ptr, r_id;
  logic [3:0]     r_a, r_b;
  logic           r_gt, r_lt, r_eq;

  logic           w_found, w_grant;
  int             w_winner;
  logic [3:0]     w_sel_a, w_sel_b;
  logic           w_gt, w_lt, w_eq;

  magnitude_comparator u_cmp (
    .i_a  (r_a),
    .i_b  (r_b),
    .o_gt (w_gt),
    .o_lt (w_lt),
    .o_eq (w_eq)
  );

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_winner = (int'(r_rr_ptr) + k) % NREQ;
      end
    end
    w_sel_a = i_req_a[4*w_winner +: 4];
    w_sel_b = i_req_b[4*w_winner +: 4];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs; grants only ever issued from IDLE.
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    o_req_ready = '0;
    o_rsp_valid = 1'b0;
    o_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
          w_next  = S_EVAL;
          for (int j = 0; j < NREQ; j++) o_req_ready[j] = (w_winner == j);
        end
      end
      S_EVAL: w_next = S_RESP;
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture on grant, result capture in EVAL; both hold otherwise,
  // which keeps the response bit-stable under backpressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      if (w_grant) begin
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_id     <= IDW'(w_winner);
        r_rr_ptr <= IDW'((w_winner + 1) % NREQ);
      end
      if (r_state == S_EVAL) begin
        r_gt <= w_gt;
        r_lt <= w_lt;
        r_eq <= w_eq;
      end
    end
  end

  assign o_rsp_id = r_id;
  assign o_rsp_gt = r_gt;
  assign o_rsp_lt = r_lt;
  assign o_rsp_eq = r_eq;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level round-robin/compare model.
module tb_cmp_share_arbiter;
  localparam int N   = 4;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [4*N-1:0]   req_a, req_b;
  logic [N-1:0]     req_ready;
  logic             rsp_valid, rsp_gt, rsp_lt, rsp_eq, rsp_ready, busy;
  logic [IDW-1:0]   rsp_id;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int id; logic [2:0] r; } exp_t;

  cmp_share_arbiter #(.NREQ(N), .IDW(IDW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_a(req_a),
    .i_req_b(req_b), .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
    .o_rsp_id(rsp_id), .o_rsp_gt(rsp_gt), .o_rsp_lt(rsp_lt), .o_rsp_eq(rsp_eq),
    .i_rsp_ready(rsp_ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // {gt,lt,eq} from plain unsigned arithmetic
  function automatic logic [2:0] ref_cmp(int a, int b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy, req_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b id=%0d res=%b busy=%b rdy=%b exp all 0",
               rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, busy, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_a[11:8] = 4'h9; req_b[11:8] = 4'h5;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++; $display("FAIL single_ready got=%b exp=0100", req_ready);
    end
    tick(); req_valid = '0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
      n_err++; $display("FAIL single_eval got v=%b busy=%b rdy=%b exp v=0 busy=1 rdy=0",
                        rsp_valid, busy, req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd2 || {rsp_gt, rsp_lt, rsp_eq} !== 3'b100) begin
      n_err++; $display("FAIL single_rsp got v=%b id=%0d res=%b exp v=1 id=2 res=100",
                        rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq});
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_idle got busy=%b v=%b exp 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ea, eb;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4] = 4'($urandom); req_b[4*i +: 4] = 4'($urandom);
    end
    req_valid = '1;
    for (int g = 0; g < 6; g++) begin
      #1;
      n_cmp++;
      if (req_ready !== onehot(g % N)) begin
        n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, onehot(g % N));
      end
      ea = req_a[4*(g%N) +: 4]; eb = req_b[4*(g%N) +: 4];
      tick();
      req_a[4*(g%N) +: 4] = 4'($urandom); req_b[4*(g%N) +: 4] = 4'($urandom);
      n_cmp++;
      if (req_ready !== '0) begin
        n_err++; $display("FAIL rr_eval_ready%0d got=%b exp=0000", g, req_ready);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != g % N ||
          {rsp_gt, rsp_lt, rsp_eq} !== ref_cmp(ea, eb)) begin
        n_err++; $display("FAIL rr_rsp%0d got v=%b id=%0d res=%b exp v=1 id=%0d res=%b",
                          g, rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, g % N, ref_cmp(ea, eb));
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] a1, b1;
    do_reset();
    req_valid = 4'b0001; req_a[3:0] = 4'h3; req_b[3:0] = 4'hC;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL bp_grant0 got=%b exp=0001", req_ready);
    end
    tick();
    a1 = 4'($urandom); b1 = 4'($urandom);
    req_valid = 4'b0011; req_a[7:4] = a1; req_b[7:4] = b1; rsp_ready = 1'b0;
    tick();
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || {rsp_gt, rsp_lt, rsp_eq} !== 3'b010 ||
          req_ready !== '0) begin
        n_err++; $display("FAIL bp_hold%0d got v=%b id=%0d res=%b rdy=%b exp v=1 id=0 res=010 rdy=0000",
                          s, rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, req_ready);
      end
      tick();
    end
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || req_ready !== '0) begin
      n_err++; $display("FAIL bp_handshake got v=%b rdy=%b exp v=1 rdy=0000", rsp_valid, req_ready);
    end
    tick();
    n_cmp++;
    if (req_ready !== 4'b0010 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_grant1 got rdy=%b busy=%b exp rdy=0010 busy=0", req_ready, busy);
    end
    tick(); req_valid = '0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || {rsp_gt, rsp_lt, rsp_eq} !== ref_cmp(a1, b1)) begin
      n_err++; $display("FAIL bp_rsp1 got v=%b id=%0d res=%b exp v=1 id=1 res=%b",
                        rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, ref_cmp(a1, b1));
    end
    tick();
  endtask

  task automatic test_extremes();
    logic [3:0] ta [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
    logic [3:0] tb [4] = '{4'hF, 4'h0, 4'h0, 4'hF};
    logic [2:0] te [4] = '{3'b001, 3'b001, 3'b100, 3'b010};
    rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      req_valid = 4'b1000; req_a[15:12] = ta[t]; req_b[15:12] = tb[t];
      #1;
      n_cmp++;
      if (req_ready !== 4'b1000) begin
        n_err++; $display("FAIL ext_grant%0d got=%b exp=1000", t, req_ready);
      end
      tick(); req_valid = '0;
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 3'd3 || {rsp_gt, rsp_lt, rsp_eq} !== te[t]) begin
        n_err++; $display("FAIL ext_rsp%0d got v=%b id=%0d res=%b exp v=1 id=3 res=%b",
                          t, rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, te[t]);
      end
      tick();
    end
  endtask

  task automatic test_exhaustive();
    int nresp = 0;
    int stall;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req_valid = 4'b0010; req_a[7:4] = 4'(a); req_b[7:4] = 4'(b);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
          n_err++; $display("FAIL exh_grant a=%0d b=%0d got=%b exp=0010", a, b, req_ready);
        end
        tick(); req_valid = '0; rsp_ready = 1'b0;
        tick();
        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) tick();
        rsp_ready = 1'b1;
        #1;
        if (rsp_valid === 1'b1) nresp++;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 ||
            {rsp_gt, rsp_lt, rsp_eq} !== ref_cmp(a, b) ||
            (32'(rsp_gt) + 32'(rsp_lt) + 32'(rsp_eq)) != 1) begin
          n_err++; $display("FAIL exh_rsp a=%0d b=%0d got v=%b id=%0d res=%b exp v=1 id=1 res=%b",
                            a, b, rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, ref_cmp(a, b));
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_err++; $display("FAIL exh_dup a=%0d b=%0d got v=%b exp v=0", a, b, rsp_valid);
        end
      end
    end
    n_cmp++;
    if (nresp != 256) begin
      n_err++; $display("FAIL exh_count got=%0d exp=256", nresp);
    end
  endtask

  task automatic test_reset_midop();
    // abort in EVAL
    do_reset();
    req_valid = 4'b0100; req_a[11:8] = 4'h5; req_b[11:8] = 4'h5;
    tick(); req_valid = '0; rst = 1'b1;
    tick(); rst = 1'b0;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy, req_ready} !== '0) begin
      n_err++; $display("FAIL rst_eval_outputs got v=%b id=%0d res=%b busy=%b rdy=%b exp all 0",
                        rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, busy, req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_eval_norsp got v=%b exp 0", rsp_valid);
    end
    req_valid = 4'b1010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++; $display("FAIL rst_eval_ptr got=%b exp=0010", req_ready);
    end
    tick(); req_valid = '0;
    tick(); tick();
    // abort in RESP
    req_valid = 4'b0100; req_a[11:8] = 4'h1; req_b[11:8] = 4'h7; rsp_ready = 1'b0;
    tick(); req_valid = '0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; rsp_ready = 1'b1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy, req_ready} !== '0) begin
      n_err++; $display("FAIL rst_resp_outputs got v=%b id=%0d res=%b busy=%b rdy=%b exp all 0",
                        rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, busy, req_ready);
    end
    req_valid = 4'b1001; req_a[3:0] = 4'hA; req_b[3:0] = 4'h2;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++; $display("FAIL rst_resp_ptr got=%b exp=0001", req_ready);
    end
    tick(); req_valid = '0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || {rsp_gt, rsp_lt, rsp_eq} !== 3'b100) begin
      n_err++; $display("FAIL rst_next_rsp got v=%b id=%0d res=%b exp v=1 id=0 res=100",
                        rsp_valid, rsp_id, {rsp_gt, rsp_lt, rsp_eq});
    end
    tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int ptr = 0;
    int acc = -1;
    int w;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (acc >= 0) req_valid[acc] = 1'b0;
      acc = -1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_a[4*i +: 4] = 4'($urandom); req_b[4*i +: 4] = 4'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!busy) begin
        w = pick(req_valid, ptr);
        n_cmp++;
        if (req_ready !== onehot(w)) begin
          n_err++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, onehot(w));
        end
        if (w >= 0) begin
          e.id = w; e.r = ref_cmp(req_a[4*w +: 4], req_b[4*w +: 4]);
          q.push_back(e);
          ptr = (w + 1) % N;
          acc = w;
        end
      end else begin
        n_cmp++;
        if (req_ready !== '0) begin
          n_err++; $display("FAIL rnd_busy_ready c=%0d got=%b exp=0000", c, req_ready);
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra_rsp c=%0d got id=%0d exp none", c, rsp_id);
        end else begin
          e = q.pop_front();
          if (int'(rsp_id) != e.id || {rsp_gt, rsp_lt, rsp_eq} !== e.r) begin
            n_err++; $display("FAIL rnd_rsp c=%0d got id=%0d res=%b exp id=%0d res=%b",
                              c, rsp_id, {rsp_gt, rsp_lt, rsp_eq}, e.id, e.r);
          end
        end
      end
      tick();
    end
    if (acc >= 0) req_valid[acc] = 1'b0;
    // drain: stop new requests and collect what is still owed
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready !== '0) begin
        n_cmp++; n_err++;
        $display("FAIL rnd_drain_grant got=%b exp=0000", req_ready);
      end
      if (rsp_valid && q.size() != 0) begin
        e = q.pop_front();
        n_cmp++;
        if (int'(rsp_id) != e.id || {rsp_gt, rsp_lt, rsp_eq} !== e.r) begin
          n_err++; $display("FAIL rnd_drain_rsp got id=%0d res=%b exp id=%0d res=%b",
                            rsp_id, {rsp_gt, rsp_lt, rsp_eq}, e.id, e.r);
        end
      end
      tick();
    end
    n_cmp++;
    if (q.size() != 0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL rnd_lost got pending=%0d v=%b exp pending=0 v=0", q.size(), rsp_valid);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_extremes();
    test_exhaustive();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_share_arbiter.md
# cmp_share_arbiter

Shares one 4-bit magnitude comparator (`magnitude_comparator`, instantiated internally) among `NREQ` requesters. Each requester submits an operand pair over a valid/ready handshake. A round-robin arbiter grants one pair at a time and registers the operands. The registered gt/lt/eq result goes out on a single response channel tagged with the requester index, and is held until the consumer accepts it.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default 3: width of `rsp_id`; must satisfy 2^IDW >= NREQ.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i high means requester i presents an operand pair.
- `req_a`  in  4*NREQ  operand A of requester i on bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B of requester i on bits [4i+3:4i].
- `req_ready`  out  NREQ  one-hot or zero; bit i high means requester i's pair is accepted this cycle.
- `rsp_valid`  out  1  response present.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_gt`, `rsp_lt`, `rsp_eq`  out  1 each  comparator result for the accepted pair.
- `rsp_ready`  in  1  consumer accepts the response when high together with `rsp_valid`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, EVAL and RESP.
- **IDLE**
  - Arbiter picks the first requester with `req_valid` set, searching upward from `rr_ptr` and wrapping from NREQ-1 to 0.
  - `req_ready[winner]` is driven high combinationally; all other bits are 0.
  - Transfer when `req_valid[i] & req_ready[i]`: latch A, B and id into operand registers, set `rr_ptr <= (winner+1) mod NREQ`, go to EVAL.
  - With no valid request, stay in IDLE and leave `rr_ptr` unchanged.
- **EVAL**
  - Comparator inputs come from the operand registers.
  - Its gt/lt/eq outputs are registered into the response registers.
  - Always go to RESP on the next edge.
- **RESP**
  - `rsp_valid` = 1; `rsp_id`, `rsp_gt`, `rsp_lt` and `rsp_eq` are stable from the registers.
  - On `rsp_valid & rsp_ready`, go to IDLE.
  - No new grant is issued in the handshake cycle.
- `req_ready` is all-zero in EVAL and RESP regardless of `req_valid`.
- A requester must hold `req_valid` and its data until it is accepted; the block never drops a request.
- Exactly one of `rsp_gt`, `rsp_lt`, `rsp_eq` is 1 whenever `rsp_valid` is high.
- Operands are unsigned 4-bit values; there is no sign handling.
- Requester indices at or above NREQ cannot exist. `rr_ptr` is `IDW` bits wide and is kept below NREQ.

## Timing
- **Reset** (edge with `rst` = 1): state = IDLE, `rr_ptr` = 0, and operand/response registers = 0.
  - Outputs after reset: `rsp_valid` = 0, `rsp_id` = 0, `rsp_gt/lt/eq` = 0, `busy` = 0.
  - `req_ready` becomes 0 in the same cycle because it is decoded from the reset state.
- **Reset mid-operation** in EVAL or RESP: the in-flight pair is discarded with no response, and the FSM returns to IDLE.
- **Latency:** accept at edge N, result registered at edge N+1, `rsp_valid` high from edge N+1.
  - The response is visible in the cycle after EVAL, i.e. 2 cycles after the grant cycle.
- **Throughput:** at most one pair per 3 cycles with `rsp_ready` tied high (IDLE, EVAL, RESP).
- **Backpressure:** while `rsp_valid & !rsp_ready`, every response output is held bit-stable and no grant is issued.
- **Simultaneous requests:** only the round-robin winner is granted; losers keep `req_valid` and are served in pointer order.
- **Grant and deassert in the same cycle:** not allowed by protocol. A pair is captured if `req_valid` is high at the edge where `req_ready` is high.
- **Starvation bound:** a continuously valid requester is granted within NREQ grants.

## Test plan
- **Single request, after reset:** requester 2 with A=9, B=5, `rsp_ready` = 1.
  - Expect `req_ready` = 0100 in the request cycle.
  - Expect `rsp_valid` 2 cycles later with `rsp_id` = 2, gt = 1, lt = 0, eq = 0.
  - Expect `busy` to drop the cycle after the response handshake.
- **Round-robin:** all 4 `req_valid` held high from reset.
  - Expect grant order 0, 1, 2, 3, 0, 1 and a grant every 3 cycles.
  - Expect `rsp_id` to follow the same order.
- **Backpressure:** requester 0 with A=3, B=12; `rsp_ready` low for 5 cycles after `rsp_valid` rises.
  - Expect `rsp_valid`, id = 0 and lt = 1 held stable for those cycles.
  - Expect `req_ready` = 0 throughout, even with requester 1 valid.
  - Requester 1 is granted the cycle after the handshake plus one (back in IDLE).
- **Equality and extremes:** (A,B) = (F,F), (0,0), (F,0), (0,F).
  - Expect eq, eq, gt, lt respectively.
- **Exhaustive:** all 256 (A,B) pairs from requester 1, each checked against a reference compare.
  - Expect exactly one of gt/lt/eq set per response and no lost or duplicated responses.
- **Reset mid-operation:** assert `rst` for 1 cycle while in EVAL, then again while in RESP.
  - Expect all outputs 0 the next cycle, `rr_ptr` back to 0, and no response for the aborted pair.
  - The next request is granted normally.
